game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Game-phase controller sitting directly upstream of the object mux. It owns the intro / running / game-over sequencing and conditions the raw Enter key. It also counts lives and crash invulnerability, and times the game-over hold and the "press Enter" blink. Its outputs are the phase/request signals the mux uses to pick layers: a one-cycle start pulse, a running level, a game-over level, and the enter-text visibility.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable synced cycles required to change the debounced key level
- BLINK_FRAMES, 30, frames per blink half-period of the enter text
- HOLD_FRAMES, 180, frames in GAME_OVER during which Enter is ignored
- INVULN_FRAMES, 60, frames after an accepted crash during which further crashes are ignored
- START_LIVES, 3, lives loaded on each INTRO->RUNNING transition (1..3)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enter_key  in  1  raw Enter key level, asynchronous to clk
- startOfFrame  in  1  one-cycle pulse per video frame
- crash  in  1  one-cycle collision pulse from the collision unit
- fuel_empty  in  1  level, fuel exhausted
- enterFirstPress  out  1  one-cycle pulse on the cycle RUNNING is entered
- game_running  out  1  high while state is RUNNING
- gameOver_req  out  1  high while state is GAME_OVER
- enter_visible  out  1  enter-text draw enable (blinks)
- lives  out  2  remaining lives
- state  out  2  INTRO=0, RUNNING=1, GAME_OVER=2; 3 unused

## Operation
- Key path: 2-flop synchronizer, then debounce counter. The counter resets whenever the synced value differs from the debounced level. The debounced level takes the synced value when the counter reaches DEBOUNCE_CYCLES-1 with the values still differing. A press is a debounced 0->1 edge, registered as one-cycle press_p.
- FSM, all outputs registered:
  - INTRO: press_p -> RUNNING. lives<=START_LIVES, invuln counter<=0, enterFirstPress<=1 for that one cycle.
  - RUNNING: an accepted crash is crash=1 with invuln counter=0.
    - Accepted crash with lives=1 -> GAME_OVER, lives<=0.
    - Accepted crash with lives>1: lives<=lives-1, invuln<=INVULN_FRAMES.
    - fuel_empty=1 -> GAME_OVER, regardless of crash. An accepted crash in the same cycle still decrements lives.
    - press_p is ignored.
  - GAME_OVER: on entry, hold counter<=HOLD_FRAMES. The counter decrements on each startOfFrame until it reaches 0. press_p while hold counter=0 -> INTRO. press_p while hold counter>0 is ignored.
- Invuln counter: decrements on startOfFrame while nonzero, in RUNNING only. It is cleared on leaving RUNNING.
- Blink:
  - On entering INTRO, or when the GAME_OVER hold counter reaches 0: enter_visible<=1 and blink counter<=0.
  - The blink counter increments on startOfFrame. When it reaches BLINK_FRAMES-1, enter_visible toggles and the counter wraps to 0.
  - enter_visible=0 in RUNNING and while the GAME_OVER hold counter>0.
- Frame counters are all bounded: no wrap below 0, saturating decrement.

## Timing
- Reset values: state=INTRO, enterFirstPress=0, game_running=0, gameOver_req=0, enter_visible=1, lives=0. Synchronizer, debounced level and all counters are 0.
- Key latency: 2 cycles sync + DEBOUNCE_CYCLES stable cycles to the debounced rise. press_p follows 1 cycle later. The state change, enterFirstPress and game_running follow 1 cycle after press_p.
- enterFirstPress is exactly one cycle wide and coincides with the first cycle of game_running=1.
- Crash to state/lives update: 1 cycle. gameOver_req and game_running change in the same cycle as state.
- Simultaneous startOfFrame and crash: both take effect in the same cycle. The crash check uses the pre-update invuln value.
- Key bounce shorter than DEBOUNCE_CYCLES never produces press_p. A held key produces exactly one press_p.
- Reset asserted mid-game returns every output to its reset value asynchronously. A key still held at reset release gives no press until it is released and pressed again.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, BLINK_FRAMES=2, HOLD_FRAMES=3, INVULN_FRAMES=2, START_LIVES=3.
- Start: in INTRO, hold enter_key high 10 cycles. Required: exactly one enterFirstPress pulse, 1+2+4+1 cycles after the first synced cycle; state=1; lives=3; game_running=1.
- Bounce: toggle enter_key every 2 cycles for 20 cycles. Required: no press_p, state stays 0.
- Crash/invuln: in RUNNING, crash pulse -> lives=2. A second crash before 2 startOfFrames -> lives stays 2. A crash after 2 startOfFrames -> lives=1. A further crash after 2 more frames -> state=2, lives=0, gameOver_req=1.
- fuel_empty and an accepted crash in the same cycle with lives=3: required state=2, lives=2.
- Game-over hold: press during the first 3 frames is ignored. After the 3rd startOfFrame enter_visible=1 and toggles every 2 frames. A press then gives state=0 and enter_visible=1.
- Reset mid-RUNNING: assert reset between clock edges. Required: outputs at reset values before the next edge; enter_key held through release gives no start.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game-phase controller: Enter-key conditioning, intro/running/game-over sequencing,
// lives and invulnerability accounting, game-over hold and enter-text blink timing.
module game_flow_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_FRAMES    = 30,
  parameter int HOLD_FRAMES     = 180,
  parameter int INVULN_FRAMES   = 60,
  parameter int START_LIVES     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_key,
  input  logic       startOfFrame,
  input  logic       crash,
  input  logic       fuel_empty,
  output logic       enterFirstPress,
  output logic       game_running,
  output logic       gameOver_req,
  output logic       enter_visible,
  output logic [1:0] lives,
  output logic [1:0] state
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 1);

  typedef enum logic [1:0] {S_INTRO = 2'd0, S_RUN = 2'd1, S_GO = 2'd2} state_t;

  // ---------------- key path ----------------
  logic [1:0]    sync, vld_pipe;
  logic [DW-1:0] db_cnt;
  logic          deb, deb_q, armed, press_p;

  // armed only after the synced key has been seen released, so a key held
  // through reset release cannot start a game
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync     <= '0;
      vld_pipe <= '0;
      db_cnt   <= '0;
      deb      <= 1'b0;
      deb_q    <= 1'b0;
      armed    <= 1'b0;
      press_p  <= 1'b0;
    end else begin
      sync     <= {sync[0], enter_key};
      vld_pipe <= {vld_pipe[0], 1'b1};
      if (sync[1] != deb) begin
        if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb    <= sync[1];
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
      deb_q <= deb;
      if (vld_pipe[1] && !sync[1] && !deb) armed <= 1'b1;
      press_p <= deb & ~deb_q & armed;
    end
  end

  // ---------------- FSM ----------------
  state_t        st_q, st_n;
  logic [1:0]    lives_q, lives_n;
  logic [IW-1:0] inv_q, inv_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [BW-1:0] blink_q, blink_n;
  logic          vis_q, vis_n, efp_q, efp_n, run_q, go_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= S_INTRO;
      lives_q <= '0;
      inv_q   <= '0;
      hold_q  <= '0;
      blink_q <= '0;
      vis_q   <= 1'b1;
      efp_q   <= 1'b0;
      run_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      st_q    <= st_n;
      lives_q <= lives_n;
      inv_q   <= inv_n;
      hold_q  <= hold_n;
      blink_q <= blink_n;
      vis_q   <= vis_n;
      efp_q   <= efp_n;
      run_q   <= (st_n == S_RUN);
      go_q    <= (st_n == S_GO);
    end
  end

  always_comb begin
    st_n    = st_q;
    lives_n = lives_q;
    inv_n   = inv_q;
    hold_n  = hold_q;
    blink_n = blink_q;
    vis_n   = vis_q;
    efp_n   = 1'b0;

    // blink runs whenever the enter text is meant to be shown; transitions below override
    if ((st_q == S_INTRO || (st_q == S_GO && hold_q == '0)) && startOfFrame) begin
      if (blink_q == BW'(BLINK_FRAMES - 1)) begin
        vis_n   = ~vis_q;
        blink_n = '0;
      end else begin
        blink_n = blink_q + BW'(1);
      end
    end

    case (st_q)
      S_INTRO: begin
        if (press_p) begin
          st_n    = S_RUN;
          lives_n = 2'(START_LIVES);
          inv_n   = '0;
          efp_n   = 1'b1;
          vis_n   = 1'b0;
          blink_n = '0;
        end
      end
      S_RUN: begin
        vis_n = 1'b0;
        if (startOfFrame && inv_q != '0) inv_n = inv_q - IW'(1);
        // crash acceptance looks at the pre-decrement invuln value
        if (crash && inv_q == '0) begin
          if (lives_q <= 2'd1) begin
            lives_n = '0;
            st_n    = S_GO;
          end else begin
            lives_n = lives_q - 2'd1;
            inv_n   = IW'(INVULN_FRAMES);
          end
        end
        if (fuel_empty) st_n = S_GO;
        if (st_n == S_GO) begin
          inv_n  = '0;
          hold_n = HW'(HOLD_FRAMES);
        end
      end
      S_GO: begin
        if (hold_q != '0) begin
          vis_n = 1'b0;
          if (startOfFrame) begin
            hold_n = hold_q - HW'(1);
            if (hold_q == HW'(1)) begin
              vis_n   = 1'b1;
              blink_n = '0;
            end
          end
        end else if (press_p) begin
          st_n    = S_INTRO;
          vis_n   = 1'b1;
          blink_n = '0;
        end
      end
      default: st_n = S_INTRO;
    endcase
  end

  assign enterFirstPress = efp_q;
  assign game_running    = run_q;
  assign gameOver_req    = go_q;
  assign enter_visible   = vis_q;
  assign lives           = lives_q;
  assign state           = st_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: vector table for per-cycle game events,
// hand-written sequences for key debounce, hold, and reset behaviour.
module tb_game_flow_ctrl;
  logic       clk = 1'b0;
  logic       reset, enter_key, startOfFrame, crash, fuel_empty;
  logic       enterFirstPress, game_running, gameOver_req, enter_visible;
  logic [1:0] lives, state;

  game_flow_ctrl #(
    .DEBOUNCE_CYCLES(4), .BLINK_FRAMES(2), .HOLD_FRAMES(3),
    .INVULN_FRAMES(2), .START_LIVES(3)
  ) dut (
    .clk(clk), .reset(reset), .enter_key(enter_key), .startOfFrame(startOfFrame),
    .crash(crash), .fuel_empty(fuel_empty), .enterFirstPress(enterFirstPress),
    .game_running(game_running), .gameOver_req(gameOver_req),
    .enter_visible(enter_visible), .lives(lives), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sof, crash, fuel;
    logic [1:0] st, lv;
    logic       run, go, vis;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(logic s, logic c, logic f, logic [1:0] st, logic [1:0] lv,
                              logic run, logic go, logic vis);
    vec_t v;
    v.sof = s; v.crash = c; v.fuel = f;
    v.st = st; v.lv = lv; v.run = run; v.go = go; v.vis = vis;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      startOfFrame = 1'b0; crash = 1'b0; fuel_empty = 1'b0;
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      startOfFrame = vec[i].sof; crash = vec[i].crash; fuel_empty = vec[i].fuel;
      @(posedge clk); #1;
      chk($sformatf("v%0d_state", i), state, vec[i].st);
      chk($sformatf("v%0d_lives", i), lives, vec[i].lv);
      chk($sformatf("v%0d_running", i), game_running, vec[i].run);
      chk($sformatf("v%0d_gameover", i), gameOver_req, vec[i].go);
      chk($sformatf("v%0d_visible", i), enter_visible, vec[i].vis);
    end
    idle(1);
  endtask

  // key press from INTRO; enterFirstPress expected on the 8th edge after the key rises
  task automatic start_game(input string nm);
    int first = -1, pulses = 0, run_at = 0;
    @(negedge clk); enter_key = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (enterFirstPress) begin
        pulses++;
        if (first < 0) begin first = i; run_at = game_running; end
      end
    end
    chk({nm, "_latency"}, first, 8);
    chk({nm, "_pulses"}, pulses, 1);
    chk({nm, "_run_with_pulse"}, run_at, 1);
    chk({nm, "_state"}, state, 1);
    chk({nm, "_lives"}, lives, 3);
    chk({nm, "_running"}, game_running, 1);
    @(negedge clk); enter_key = 1'b0;
    idle(10);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int bad, first;
    // crash / invulnerability, pre-update invuln on simultaneous frame+crash
    vec.push_back(mk(0, 1, 0, 1, 2, 1, 0, 0)); // 0 accepted crash
    vec.push_back(mk(0, 1, 0, 1, 2, 1, 0, 0)); // 1 ignored
    vec.push_back(mk(1, 0, 0, 1, 2, 1, 0, 0)); // 2 invuln 1
    vec.push_back(mk(0, 1, 0, 1, 2, 1, 0, 0)); // 3 ignored
    vec.push_back(mk(1, 0, 0, 1, 2, 1, 0, 0)); // 4 invuln 0
    vec.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0)); // 5 accepted
    vec.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0)); // 6 invuln 1
    vec.push_back(mk(1, 1, 0, 1, 1, 1, 0, 0)); // 7 frame+crash: crash ignored
    vec.push_back(mk(0, 1, 0, 2, 0, 0, 1, 0)); // 8 last life -> game over
    // game-over hold then blink
    vec.push_back(mk(1, 0, 0, 2, 0, 0, 1, 0)); // 9  hold 2
    vec.push_back(mk(1, 0, 0, 2, 0, 0, 1, 0)); // 10 hold 1
    vec.push_back(mk(1, 0, 0, 2, 0, 0, 1, 1)); // 11 hold 0, visible
    vec.push_back(mk(1, 0, 0, 2, 0, 0, 1, 1)); // 12 blink 1
    vec.push_back(mk(1, 0, 0, 2, 0, 0, 1, 0)); // 13 toggle off
    vec.push_back(mk(1, 0, 0, 2, 0, 0, 1, 0)); // 14
    vec.push_back(mk(1, 0, 0, 2, 0, 0, 1, 1)); // 15 toggle on
    vec.push_back(mk(0, 0, 0, 2, 0, 0, 1, 1)); // 16 no frame
    // fuel empty with an accepted crash, lives 3
    vec.push_back(mk(0, 1, 1, 2, 2, 0, 1, 0)); // 17

    reset = 1'b1; enter_key = 1'b0; startOfFrame = 1'b0; crash = 1'b0; fuel_empty = 1'b0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 0);
    chk("rst_visible", enter_visible, 1);
    chk("rst_running", game_running, 0);
    chk("rst_gameover", gameOver_req, 0);
    chk("rst_efp", enterFirstPress, 0);
    @(negedge clk); reset = 1'b0;
    idle(5);

    // bounce: 2-cycle toggles never satisfy a 4-cycle debounce
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 2 == 0) enter_key = ~enter_key;
      @(posedge clk); #1;
      if (enterFirstPress || state != 2'd0) bad++;
    end
    chk("bounce_no_start", bad, 0);
    @(negedge clk); enter_key = 1'b0;
    idle(10);

    start_game("start1");
    run_vecs(0, 8);

    // press while hold counter nonzero is ignored
    bad = 0;
    @(negedge clk); enter_key = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (state != 2'd2 || enter_visible) bad++;
    end
    chk("hold_press_ignored", bad, 0);
    @(negedge clk); enter_key = 1'b0;
    idle(10);

    run_vecs(9, 16);

    // press after hold expires returns to INTRO
    first = -1;
    @(negedge clk); enter_key = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (first < 0 && state == 2'd0) first = i;
    end
    chk("go_exit_latency", first, 8);
    chk("go_exit_visible", enter_visible, 1);
    chk("go_exit_gameover", gameOver_req, 0);
    @(negedge clk); enter_key = 1'b0;
    idle(10);

    start_game("start2");

    // async reset mid-RUNNING, key held through release
    @(posedge clk); #2;
    reset = 1'b1; enter_key = 1'b1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_lives", lives, 0);
    chk("midrst_visible", enter_visible, 1);
    chk("midrst_running", game_running, 0);
    chk("midrst_gameover", gameOver_req, 0);
    chk("midrst_efp", enterFirstPress, 0);
    @(negedge clk); reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (enterFirstPress || state != 2'd0) bad++;
    end
    chk("held_key_no_start", bad, 0);
    @(negedge clk); enter_key = 1'b0;
    idle(10);

    start_game("start3");
    run_vecs(17, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
